// File: rtl/cond_unit.sv
//==============================================================================
// Module   : cond_unit
// Brief    : Architectural N/Z/C/V flag register with branch-condition decode
//            and a small LIFO flag stack for interrupt entry/return.
//            Optional macro COND_FORWARD_EN bypasses a same-cycle cc_we into
//            the branch evaluation.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cond_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cc_in,
    input  logic       cc_we,
    input  logic       br_valid,
    input  logic [3:0] br_cond,
    output logic       taken_valid,
    output logic       taken,
    output logic [3:0] flags,
    input  logic       push,
    input  logic       pop,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(STACK_DEPTH - 1);

    logic [3:0]       flags_q, flags_d;
    logic [PTR_W-1:0] sp_q, sp_d;
    logic             full_q, full_d;
    logic             err_q, err_d;
    logic             tv_q;
    logic             tk_q, tk_d;
    logic [3:0]       stack_q [STACK_DEPTH];
    logic             st_we;
    logic [PTR_W-1:0] st_waddr;
    logic [PTR_W-1:0] sp_m1;
    logic [3:0]       top;
    logic [3:0]       eval_flags;
    logic             empty;

    function automatic logic cond_eval(input logic [3:0] sel, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        r = 1'b0;
        case (sel)
            4'd0:  r = z;
            4'd1:  r = !z;
            4'd2:  r = c;
            4'd3:  r = !c;
            4'd4:  r = n;
            4'd5:  r = !n;
            4'd6:  r = v;
            4'd7:  r = !v;
            4'd8:  r = c & !z;
            4'd9:  r = !c | z;
            4'd10: r = (n == v);
            4'd11: r = (n != v);
            4'd12: r = !z & (n == v);
            4'd13: r = z | (n != v);
            4'd14: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // sp wraps to 0 when the stack fills; full_q tells full apart from empty
    assign empty = (sp_q == '0) && !full_q;
    assign sp_m1 = sp_q - 1'b1;
    assign top   = stack_q[sp_m1];

    always_comb begin
        flags_d  = flags_q;
        sp_d     = sp_q;
        full_d   = full_q;
        err_d    = err_q;
        st_we    = 1'b0;
        st_waddr = sp_q;
        if (cc_we) begin
            flags_d = cc_in;
        end
        if (push && pop && !empty) begin
            flags_d  = top;
            st_we    = 1'b1;
            st_waddr = sp_m1;
        end else if (push) begin
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                st_we  = 1'b1;
                sp_d   = sp_q + 1'b1;
                full_d = (sp_q == LAST_IDX);
            end
        end else if (pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                flags_d = top;
                sp_d    = sp_m1;
                full_d  = 1'b0;
            end
        end
    end

`ifdef COND_FORWARD_EN
    // flags_d already resolves pop-over-cc_we priority for the bypass
    assign eval_flags = cc_we ? flags_d : flags_q;
`else
    assign eval_flags = flags_q;
`endif

    assign tk_d = br_valid ? cond_eval(br_cond, eval_flags) : tk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0;
            sp_q    <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            tv_q    <= 1'b0;
            tk_q    <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            full_q  <= full_d;
            err_q   <= err_d;
            tv_q    <= br_valid;
            tk_q    <= tk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && st_we) begin
            stack_q[st_waddr] <= flags_q;
        end
    end

    assign taken_valid = tv_q;
    assign taken       = tk_q;
    assign flags       = flags_q;
    assign stack_empty = empty;
    assign stack_full  = full_q;
    assign stack_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cond_unit.sv
//==============================================================================
// Module   : tb_cond_unit
// Brief    : Scoreboard bench for cond_unit against a queue-based flag model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cond_unit;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, cc_we, br_valid, push, pop;
    logic [3:0] cc_in, br_cond;
    logic       taken_valid, taken, stack_empty, stack_full, stack_err;
    logic [3:0] flags;

    cond_unit #(.STACK_DEPTH(D), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .cc_in(cc_in), .cc_we(cc_we),
        .br_valid(br_valid), .br_cond(br_cond),
        .taken_valid(taken_valid), .taken(taken), .flags(flags),
        .push(push), .pop(pop),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tv;
        logic       tk;
        logic [3:0] fl;
        logic       em;
        logic       fu;
        logic       er;
    } st_t;

    int tests = 0;
    int fails = 0;

    logic       brq[$];
    st_t        sq[$];
    logic [3:0] m_stack[$];
    logic [3:0] m_flags = 4'b0;
    logic       m_err = 1'b0;
    logic       m_tk = 1'b0;

    function automatic logic ref_cond(input logic [3:0] sel, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (sel)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model updated from the pre-edge state
    task automatic step(input logic r, input logic we, input logic [3:0] c,
                        input logic bv, input logic [3:0] bc,
                        input logic pu, input logic po);
        logic [3:0] nf, ev, t;
        st_t e;
        rst = r; cc_we = we; cc_in = c; br_valid = bv; br_cond = bc; push = pu; pop = po;
        e.tv = 1'b0;
        if (r) begin
            m_flags = 4'b0;
            m_stack.delete();
            m_err = 1'b0;
            m_tk = 1'b0;
        end else begin
            nf = we ? c : m_flags;
            if (pu && po && m_stack.size() > 0) begin
                t = m_stack.pop_back();
                m_stack.push_back(m_flags);
                nf = t;
            end else if (pu) begin
                if (m_stack.size() < D) m_stack.push_back(m_flags);
                else m_err = 1'b1;
            end else if (po) begin
                if (m_stack.size() > 0) nf = m_stack.pop_back();
                else m_err = 1'b1;
            end
            ev = m_flags;
`ifdef COND_FORWARD_EN
            if (we) ev = nf;
`endif
            if (bv) begin
                m_tk = ref_cond(bc, ev);
                brq.push_back(m_tk);
                e.tv = 1'b1;
            end
            m_flags = nf;
        end
        e.tk = m_tk;
        e.fl = m_flags;
        e.em = (m_stack.size() == 0);
        e.fu = (m_stack.size() == D);
        e.er = m_err;
        @(posedge clk);
        #1;
        sq.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Monitor: per-cycle status check plus scoreboard pop on each taken_valid
    always @(negedge clk) begin
        st_t e;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("taken_valid", {3'b0, taken_valid}, {3'b0, e.tv});
            chk("taken",       {3'b0, taken},       {3'b0, e.tk});
            chk("flags",       flags,               e.fl);
            chk("stack_empty", {3'b0, stack_empty}, {3'b0, e.em});
            chk("stack_full",  {3'b0, stack_full},  {3'b0, e.fu});
            chk("stack_err",   {3'b0, stack_err},   {3'b0, e.er});
        end
        if (taken_valid === 1'b1) begin
            if (brq.size() == 0) begin
                chk("spurious_taken_valid", 4'd1, 4'd0);
            end else begin
                chk("sb_taken", {3'b0, taken}, {3'b0, brq.pop_front()});
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

        // Z set then EQ / NE
        step(1'b0, 1'b1, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'd1, 1'b0, 1'b0);
        idle();

        // Full decode sweep
        for (int f = 0; f < 16; f++) begin
            step(1'b0, 1'b1, 4'(f), 1'b0, 4'h0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++)
                step(1'b0, 1'b0, 4'h0, 1'b1, 4'(c), 1'b0, 1'b0);
        end

        // Same-cycle cc_we with branch from flags=0
        step(1'b0, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b0100, 1'b1, 4'd0, 1'b0, 1'b0);
        idle();

        // Push / overwrite / pop restore
        step(1'b0, 1'b1, 4'b1010, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        idle();

        // Five pushes (each loading new flags), then five pops
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b1, 4'(k + 3), 1'b0, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 4'h0, 1'b1, 4'(k), 1'b0, 1'b1);
        idle();

        // Swap on push+pop, pop-beats-cc_we, push+pop on empty
        step(1'b0, 1'b1, 4'b1100, 1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'b0011, 1'b1, 4'd10, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'b1111, 1'b1, 4'd2, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'b0110, 1'b0, 4'h0, 1'b1, 1'b1);
        idle();

        // Reset in the middle of a branch stream
        for (int k = 0; k < 8; k++)
            step(k == 4, 1'b1, 4'(k * 5), 1'b1, 4'(k + 8), 1'b0, 1'b0);
        idle();

        // Random traffic
        for (int k = 0; k < 600; k++)
            step(($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));

        idle();
        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 4'(brq.size()), 4'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
